// File: rtl/downcounter_ctrl.sv
// Sequencing controller for an external WIDTH-bit down-counter: one-shot or auto-reload runs
// with start/busy/done handshake. Outputs registered except cnt_en_o (combinational on cnt_co_i).
module downcounter_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] period_i,
    input  logic [WIDTH-1:0] reps_i,
    input  logic             cnt_co_i,
    output logic             cnt_load_o,
    output logic             cnt_en_o,
    output logic [WIDTH-1:0] cnt_dta_o,
    output logic             busy_o,
    output logic             tick_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic             err_o,
    output logic [WIDTH-1:0] expiries_o
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic             mode_q;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] reps_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] expiries_q;
    logic [WIDTH-1:0] expiries_d;
    logic             cnt_load_q;
    logic             busy_q;
    logic             tick_q;
    logic             done_q;
    logic             aborted_q;
    logic             err_q;

    assign expiries_d = expiries_q + ONE;

    // rem_q shadows the counter value so tick can be registered and coincide with the Q == 0 cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            period_q   <= '0;
            reps_q     <= '0;
            rem_q      <= '0;
            expiries_q <= '0;
            cnt_load_q <= 1'b0;
            busy_q     <= 1'b0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_load_q <= 1'b0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && !stop_i) begin
                        if (period_i != '0) begin
                            mode_q     <= mode_i;
                            period_q   <= period_i;
                            reps_q     <= reps_i;
                            expiries_q <= '0;
                            aborted_q  <= 1'b0;
                            err_q      <= 1'b0;
                            cnt_load_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= LOAD;
                        end else begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                LOAD: begin
                    if (stop_i) begin
                        aborted_q <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        rem_q   <= period_q;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        aborted_q <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else if (cnt_co_i) begin
                        // expiries_q already holds the post-increment count of this expiry
                        if (!mode_q || (reps_q != '0 && expiries_q == reps_q)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cnt_load_q <= 1'b1;
                            state_q    <= LOAD;
                        end
                    end else begin
                        rem_q <= rem_q - ONE;
                        if (rem_q == ONE) begin
                            tick_q     <= 1'b1;
                            expiries_q <= expiries_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cnt_en_o   = (state_q == RUN) && !cnt_co_i;
    assign cnt_load_o = cnt_load_q;
    assign cnt_dta_o  = period_q;
    assign busy_o     = busy_q;
    assign tick_o     = tick_q;
    assign done_o     = done_q;
    assign aborted_o  = aborted_q;
    assign err_o      = err_q;
    assign expiries_o = expiries_q;

endmodule

// File: tb/tb_downcounter_ctrl.sv
// Directed bench for downcounter_ctrl with a behavioural 8-bit down-counter closing the loop.
module tb_downcounter_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, mode;
    logic [7:0] period, reps;
    logic       cnt_co, cnt_load, cnt_en, busy, tick, done, aborted, err;
    logic [7:0] cnt_dta, expiries;
    logic [7:0] cnt_q = 8'd0;

    int n_vec = 0;
    int n_err = 0;
    int en_co_viol = 0;

    always #5 clk = ~clk;

    downcounter_ctrl #(.WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .mode_i(mode),
        .period_i(period), .reps_i(reps), .cnt_co_i(cnt_co),
        .cnt_load_o(cnt_load), .cnt_en_o(cnt_en), .cnt_dta_o(cnt_dta),
        .busy_o(busy), .tick_o(tick), .done_o(done), .aborted_o(aborted),
        .err_o(err), .expiries_o(expiries)
    );

    // Counter model: load has priority over en; Co is combinational on Q == 0.
    always @(posedge clk) begin
        if (cnt_load) cnt_q <= cnt_dta;
        else if (cnt_en) cnt_q <= cnt_q - 8'd1;
    end
    assign cnt_co = (cnt_q == 8'd0);

    always @(negedge clk) begin
        if (cnt_en && cnt_co) en_co_viol = en_co_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic m, input logic [7:0] p, input logic [7:0] r);
        mode = m; period = p; reps = r; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; period = 8'd0; reps = 8'd0;
        step(); step();
        chk("rst busy", busy, 0);       chk("rst tick", tick, 0);
        chk("rst done", done, 0);       chk("rst aborted", aborted, 0);
        chk("rst err", err, 0);         chk("rst expiries", expiries, 0);
        chk("rst load", cnt_load, 0);   chk("rst dta", cnt_dta, 0);
        chk("rst en", cnt_en, 0);
        rst = 1'b0;
        step();

        // One-shot P=3: LOAD at k=0, tick at k=4, done at k=5
        kick(1'b0, 8'd3, 8'd0);
        chk("os load", cnt_load, 1);
        chk("os dta", cnt_dta, 3);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("os busy k=%0d", k), busy, (k <= 4));
            chk($sformatf("os tick k=%0d", k), tick, (k == 4));
            chk($sformatf("os done k=%0d", k), done, (k == 5));
            step();
        end
        chk("os expiries", expiries, 1);
        chk("os aborted", aborted, 0);

        // Periodic P=2 R=3, inputs changed after start and a start pulse while busy
        kick(1'b1, 8'd2, 8'd3);
        mode = 1'b0; period = 8'd9; reps = 8'd1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("per busy k=%0d", k), busy, (k < 12));
            chk($sformatf("per tick k=%0d", k), tick, (k == 3 || k == 7 || k == 11));
            chk($sformatf("per done k=%0d", k), done, (k == 12));
            start = (k == 5);
            step();
        end
        start = 1'b0;
        chk("per expiries", expiries, 3);
        chk("per aborted", aborted, 0);
        chk("per dta", cnt_dta, 2);

        // Periodic P=1 unlimited, stop during cycle k=10 (RUN with Q=1)
        kick(1'b1, 8'd1, 8'd0);
        for (int k = 0; k < 14; k++) begin
            chk($sformatf("stp busy k=%0d", k), busy, (k <= 10));
            chk($sformatf("stp tick k=%0d", k), tick, (k == 2 || k == 5 || k == 8));
            chk($sformatf("stp done k=%0d", k), done, (k == 11));
            stop = (k == 10);
            step();
        end
        stop = 1'b0;
        chk("stp expiries", expiries, 3);
        chk("stp aborted", aborted, 1);

        // P=0 start is rejected
        kick(1'b0, 8'd0, 8'd0);
        chk("p0 done", done, 1);
        chk("p0 err", err, 1);
        chk("p0 busy", busy, 0);
        chk("p0 load", cnt_load, 0);
        step();
        chk("p0 done2", done, 0);
        chk("p0 busy2", busy, 0);
        chk("p0 load2", cnt_load, 0);
        chk("p0 err2", err, 1);
        step();

        // start together with stop in IDLE is ignored
        stop = 1'b1;
        kick(1'b0, 8'd5, 8'd0);
        stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ss busy k=%0d", k), busy, 0);
            chk($sformatf("ss load k=%0d", k), cnt_load, 0);
            chk($sformatf("ss done k=%0d", k), done, 0);
            step();
        end
        chk("ss expiries", expiries, 3);
        chk("ss err", err, 1);

        // Reset in the middle of a long run
        kick(1'b0, 8'd200, 8'd0);
        for (int k = 0; k < 20; k++) step();
        chk("mr busy", busy, 1);
        chk("mr en", cnt_en, 1);
        rst = 1'b1;
        step();
        chk("mr2 busy", busy, 0);       chk("mr2 done", done, 0);
        chk("mr2 tick", tick, 0);       chk("mr2 en", cnt_en, 0);
        chk("mr2 load", cnt_load, 0);   chk("mr2 dta", cnt_dta, 0);
        chk("mr2 expiries", expiries, 0);
        chk("mr2 aborted", aborted, 0); chk("mr2 err", err, 0);
        rst = 1'b0;
        step();
        chk("mr3 done", done, 0);

        // Fresh one-shot after reset, P=2: tick at k=3, done at k=4
        kick(1'b0, 8'd2, 8'd0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("ar busy k=%0d", k), busy, (k <= 3));
            chk($sformatf("ar tick k=%0d", k), tick, (k == 3));
            chk($sformatf("ar done k=%0d", k), done, (k == 4));
            step();
        end
        chk("ar expiries", expiries, 1);

        chk("en_co overlap", en_co_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/downcounter_ctrl.md
# downcounter_ctrl

Sequencing controller for the 8-bit `downcounter` datapath. It drives the counter's `load`, `en` and `dta` inputs and watches `Co` to run one-shot or auto-reload (periodic) timing runs. It reports each expiry as a `tick` pulse and ends each run with a `done` pulse through a start/busy/done handshake. It sits between a host FSM or register block and one `downcounter` instance.

## Interface
- `WIDTH`, default 8: counter and period width.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a run; sampled only in IDLE.
- `stop`  in  1  abort the current run; sampled in LOAD/RUN.
- `mode`  in  1  0 = one-shot, 1 = periodic (auto-reload); latched at start.
- `period`  in  WIDTH  reload value P; latched at start.
- `reps`  in  WIDTH  periodic expiry limit R; 0 = unlimited; latched at start.
- `cnt_co`  in  1  counter `Co`; high when counter Q == 0.
- `cnt_load`  out  1  to counter `load`; loads `cnt_dta` on the edge.
- `cnt_en`  out  1  to counter `en`; decrements by 1 per edge.
- `cnt_dta`  out  WIDTH  to counter `dta`; equals latched P.
- `busy`  out  1  high in LOAD and RUN.
- `tick`  out  1  one-cycle pulse per expiry.
- `done`  out  1  one-cycle pulse at end of run.
- `aborted`  out  1  status: last run ended by `stop`.
- `err`  out  1  status: last start was rejected because P == 0.
- `expiries`  out  WIDTH  expiries in the current or last run; wraps modulo 2^WIDTH.

## Operation
- Counter contract: `load` has priority over `en`. `Co` is combinational on Q == 0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: `cnt_load`=0, `cnt_en`=0.
  - `start`=1, `stop`=0, P≠0: latch mode/P/R, clear `expiries`, `aborted`, `err`, then go to LOAD.
  - `start`=1, P=0: set `err`=1, pulse `done` in the next cycle through DONE, never enter LOAD.
  - `start` and `stop` both high: `stop` wins and the start is ignored.
- LOAD: `cnt_load`=1 for exactly one cycle, then go to RUN.
- RUN: `cnt_en` = ~`cnt_co`. The counter never wraps through 0.
- Expiry (RUN and `cnt_co`=1):
  - Pulse `tick`; `expiries` increments on the same edge.
  - One-shot, or periodic with R≠0 and post-increment count == R: go to DONE.
  - Otherwise go to LOAD (reload).
- `stop` in LOAD or RUN: set `aborted`=1 and go to DONE. A `stop` coinciding with an expiry still counts that tick.
- DONE: `done`=1 for one cycle, `busy`=0, then go to IDLE.
- `start` outside IDLE is ignored, and no queueing occurs.
- `cnt_dta` is held at latched P in every state.

## Timing
- Reset values (edge with `rst`=1): state IDLE; `cnt_load`, `cnt_en`, `busy`, `tick`, `done`, `aborted`, `err` = 0; `expiries`=0; `cnt_dta`=0. Reset mid-run takes effect on that edge with no `done` pulse.
- Start sampled at edge E0:
  - LOAD runs in the cycle after E0.
  - After E1, counter Q = P.
  - RUN lasts P+1 cycles (Q = P..0).
  - `tick` is high in the cycle after E(P+1).
- Period between consecutive periodic ticks: P+2 cycles.
- `done` follows the final tick by 1 cycle. `busy` is high for (P+2) × expiries cycles.
- All outputs are registered (Moore), except `cnt_en`, which is combinational from state and `cnt_co`.
- Earliest new start: the first cycle back in IDLE, i.e. one cycle after `done`.

## Test plan
- Reset then one-shot, P=3, start at E0:
  - `busy` high for 5 cycles.
  - `tick` in the cycle after E4, `done` in the cycle after E5.
  - `expiries`=1, `cnt_en` never high while `cnt_co`=1.
- Periodic, P=2, R=3:
  - Ticks at 4-cycle spacing, exactly 3 ticks, then `done`.
  - `expiries`=3, `aborted`=0.
- Periodic, P=1, R=0, `stop` after 10 cycles in RUN:
  - Ticks every 3 cycles while running.
  - `done` one cycle after stop, `aborted`=1, `busy` low in the cycle after `done`.
- `start` with P=0:
  - `err`=1 and `done` pulse, `busy` never rises, `cnt_load` never rises.
- `start` pulsed while busy, and `start` together with `stop` in IDLE: both ignored, with no change to `expiries`.
- `rst` asserted in RUN with P=200: all outputs return to reset values on that edge, no `done` pulse, and a new start works.
